or1200_mac_acc: RTL and testbench
=================================

OR1200_MAC_ACC -- requirements
Module: or1200_mac_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 64, accumulator width (legal range 64..72).
REQ-002 SHALL have port clk, input, 1, single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port op_valid, input, 1, operation request.
REQ-005 SHALL have port op_ready, output, 1, stage 1 can accept an operation.
REQ-006 SHALL have port op_code, input, 2, operation: MUL=0, MAC=1, MSB=2, MACRC=3.
REQ-007 SHALL have ports opa and opb, input, 32 each, signed operands.
REQ-008 SHALL have port flush, input, 1, pipeline flush request (exception).
REQ-009 SHALL have port res_valid, output, 1, result register holds a result.
REQ-010 SHALL have port res_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port res_data, output, 32, result value.
REQ-012 SHALL have port res_ov, output, 1, MUL overflow: product does not fit in signed 32 bits.
REQ-013 SHALL have ports mac_hi and mac_lo, output, 32 each, accumulator bits [63:32] and [31:0].

Function
REQ-014 SHALL accept an operation into stage-1 registers (s1_valid, op, opa, opb) on an edge where op_valid, op_ready and !flush are all high.
REQ-015 SHALL feed the stage-1 operands combinationally to the multiplier, producing a 64-bit signed product P.
REQ-016 SHALL retire stage 1 on the edge after acceptance (latency 1 to state, 2 cycles to res_valid) whenever "advance" is true.
- advance = !writes_res | !res_valid | res_ready
- writes_res is true for MUL and MACRC.
REQ-017 SHALL drive op_ready = !s1_valid | advance, evaluated in the same cycle, so that back-to-back throughput is 1 operation per cycle.
REQ-018 SHALL, on MUL retire: set res_data=P[31:0], set res_ov = (P[63:31] not all-equal), and leave the accumulator unchanged.
REQ-019 SHALL, on MAC retire: set acc = acc + sign_extend(P); res_valid is not set.
REQ-020 SHALL, on MSB retire: set acc = acc - sign_extend(P); res_valid is not set.
REQ-021 SHALL, on MACRC retire: set res_data=acc[31:0], res_ov=0, then set acc=0 on the same edge.
- A MAC retiring on the previous edge SHALL be included in the value read.
REQ-022 SHALL wrap accumulator arithmetic modulo 2^ACC_W when saturation is not compiled in.
REQ-023 SHALL set res_valid on a writes_res retire and clear it on a res_ready handshake without a new retire.
- On a simultaneous handshake and retire, res_valid SHALL stay 1 and carry the new data.
REQ-024 SHALL hold res_data and res_ov stable while res_valid && !res_ready.
REQ-025 SHALL, on flush: clear s1_valid and drop any op_valid presented in the same cycle (flush has priority).
- The accumulator and a result already in the result register SHALL be kept.
REQ-026 SHALL drive mac_hi/mac_lo directly from the acc register with no extra latency.

Reset
REQ-027 SHALL, while rst_n=0, asynchronously force s1_valid=0, res_valid=0, res_data=0, res_ov=0 and acc=0.
- Consequently op_ready=1 and mac_hi=mac_lo=0.
REQ-028 SHALL, on reset assertion mid-operation, discard the in-flight operation and the result without a retire side-effect.
REQ-029 SHALL accept a new operation on the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, when OR1200_MAC_SATURATE_EN is defined, saturate MAC/MSB results.
- Positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
- A sticky output port sat_flag SHALL be added, set on any clamp and cleared by MACRC retire or reset.
REQ-031 SHALL, when OR1200_MAC_SATURATE_EN is undefined, wrap accumulator arithmetic and omit port sat_flag.

Structure
REQ-032 SHALL place the op_code encodings (MUL, MAC, MSB, MACRC) and the operand width constant 32 in a shared package or1200_mac_pkg.
REQ-033 SHALL instantiate sub-module or1200_mult_32x32 (combinational 32x32->64 signed) between the stage-1 registers and the retire logic; no other sub-modules.

Verification
REQ-034 SHALL cover: MUL opa=7, opb=-3 -> res_valid two cycles after accept; res_data=0xFFFFFFEB, res_ov=0.
REQ-035 SHALL cover: MUL 0x00010000 x 0x00010000 -> res_data=0, res_ov=1.
REQ-036 SHALL cover: back-to-back MAC(3,4), MAC(5,6), MSB(2,2), MACRC with res_ready=1.
- Required response: op_ready stays 1; MACRC result=38; afterwards mac_hi=mac_lo=0.
REQ-037 SHALL cover: res_ready=0 holding a MUL result, then another MUL issued.
- Required response: op_ready drops after the second accept; res_data stays unchanged; on res_ready=1 the second result appears the next cycle.
REQ-038 SHALL cover: MAC(1,1) accepted, flush in the following cycle with op_valid=1 -> acc unchanged (0); the op presented during flush is dropped.
- Also: rst_n pulsed low mid-MAC -> all outputs 0.
REQ-039 SHALL cover, with OR1200_MAC_SATURATE_EN: acc=0x7FFFFFFFFFFFFFF0 then MAC(4,4).
- Required response: acc=0x7FFFFFFFFFFFFFFF, sat_flag=1; MACRC clears sat_flag.

Source files
------------

// File: rtl/or1200_mac_pkg.sv
// Shared definitions for the OR1200 multiply/accumulate unit:
// operand width, op_code encodings and a small decode helper.
package or1200_mac_pkg;

  localparam int OPW = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'd0,
    OP_MAC   = 2'd1,
    OP_MSB   = 2'd2,
    OP_MACRC = 2'd3
  } mac_op_e;

  // True for operations that deliver a value into the result register.
  function automatic logic op_writes_res(input mac_op_e op);
    return (op == OP_MUL) || (op == OP_MACRC);
  endfunction

endpackage

// File: rtl/or1200_mult_32x32.sv
// Combinational 32x32 -> 64 signed multiplier.
module or1200_mult_32x32
  import or1200_mac_pkg::*;
(
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [2*OPW-1:0] p
);

  logic [2*OPW-1:0] a_ext;
  logic [2*OPW-1:0] b_ext;

  // Sign-extend both operands to full product width, then multiply.
  always_comb begin
    a_ext = {{OPW{a[OPW-1]}}, a};
    b_ext = {{OPW{b[OPW-1]}}, b};
    p     = a_ext * b_ext;
  end

endmodule

// File: rtl/or1200_mac_acc.sv
// OR1200 MAC unit: one operand stage feeding a signed multiplier, then a
// retire step that updates either the result register (MUL, MACRC) or the
// accumulator (MAC, MSB). Define OR1200_MAC_SATURATE_EN to clamp the
// accumulator instead of wrapping and to add the sticky sat_flag port.
module or1200_mac_acc
  import or1200_mac_pkg::*;
#(
  parameter int ACC_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_code,
  input  logic [OPW-1:0]   opa,
  input  logic [OPW-1:0]   opb,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [OPW-1:0]   res_data,
  output logic             res_ov,
  output logic [OPW-1:0]   mac_hi,
  output logic [OPW-1:0]   mac_lo
`ifdef OR1200_MAC_SATURATE_EN
  ,
  output logic             sat_flag
`endif
);

  // Stage-1 operation registers.
  logic             s1_valid_q, s1_valid_d;
  mac_op_e          s1_op_q,    s1_op_d;
  logic [OPW-1:0]   s1_opa_q,   s1_opa_d;
  logic [OPW-1:0]   s1_opb_q,   s1_opb_d;

  // Result register and accumulator.
  logic             res_valid_q, res_valid_d;
  logic [OPW-1:0]   res_data_q,  res_data_d;
  logic             res_ov_q,    res_ov_d;
  logic [ACC_W-1:0] acc_q,       acc_d;
  logic             sat_q,       sat_d;

  logic             writes_res;
  logic             advance;
  logic             accept;
  logic             retire;
  logic [2*OPW-1:0] prod;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] acc_arith;
  logic             acc_clamp;

  or1200_mult_32x32 u_mult (
    .a (s1_opa_q),
    .b (s1_opb_q),
    .p (prod)
  );

  // Handshake: stage 1 retires unless its result would overwrite an untaken one.
  always_comb begin
    writes_res = op_writes_res(s1_op_q);
    advance    = !writes_res || !res_valid_q || res_ready;
    op_ready   = !s1_valid_q || advance;
    accept     = op_valid && op_ready && !flush;
    retire     = s1_valid_q && advance && !flush;
  end

  // Signed product widened to the accumulator, negated for MSB.
  always_comb begin
    addend = ACC_W'($signed(prod));
    if (s1_op_q == OP_MSB) begin
      addend = -addend;
    end
  end

`ifdef OR1200_MAC_SATURATE_EN
  logic [ACC_W:0] acc_sum;

  // One guard bit exposes signed overflow; clamp toward its true sign.
  always_comb begin
    acc_sum   = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};
    acc_clamp = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
    if (!acc_clamp) begin
      acc_arith = acc_sum[ACC_W-1:0];
    end else if (acc_sum[ACC_W]) begin
      acc_arith = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_arith = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  // Plain modular accumulation.
  always_comb begin
    acc_arith = acc_q + addend;
    acc_clamp = 1'b0;
  end
`endif

  // Next-state for stage 1, result register and accumulator.
  always_comb begin
    // NOTE: every output gets its hold value first so no path leaves it unassigned (no latch).
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_opa_d    = s1_opa_q;
    s1_opb_d    = s1_opb_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_ov_d    = res_ov_q;
    acc_d       = acc_q;
    sat_d       = sat_q;

    // Flush wins over a same-cycle request; a retiring op just leaves.
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = mac_op_e'(op_code);
      s1_opa_d   = opa;
      s1_opb_d   = opb;
    end else if (retire) begin
      s1_valid_d = 1'b0;
    end

    // A taken result empties the register unless a new one lands on the same edge.
    if (res_ready) begin
      res_valid_d = 1'b0;
    end

    if (retire) begin
      case (s1_op_q)
        OP_MUL: begin
          res_valid_d = 1'b1;
          res_data_d  = prod[OPW-1:0];
          res_ov_d    = !((&prod[2*OPW-1:OPW-1]) || !(|prod[2*OPW-1:OPW-1]));
        end
        OP_MAC, OP_MSB: begin
          acc_d = acc_arith;
          sat_d = sat_q || acc_clamp;
        end
        OP_MACRC: begin
          res_valid_d = 1'b1;
          res_data_d  = acc_q[OPW-1:0];
          res_ov_d    = 1'b0;
          acc_d       = '0;
          sat_d       = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // State registers; reset discards any in-flight operation and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand registers are reset too, keeping the multiplier input defined after reset.
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_MUL;
      s1_opa_q    <= '0;
      s1_opb_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ov_q    <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_opa_q    <= s1_opa_d;
      s1_opb_q    <= s1_opb_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ov_q    <= res_ov_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ov    = res_ov_q;
  assign mac_hi    = acc_q[63:32];
  assign mac_lo    = acc_q[31:0];

`ifdef OR1200_MAC_SATURATE_EN
  assign sat_flag  = sat_q;
`else
  // Sticky flag only exists in the saturating build.
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_or1200_mac_acc.sv
// Self-checking bench for or1200_mac_acc: MUL vectors from a table, results
// checked through a scoreboard queue, plus hand sequences for back-to-back
// accumulation, back-pressure, flush and reset.
module tb_or1200_mac_acc;
  import or1200_mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] opa, opb;
  logic        flush;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_ov;
  logic [31:0] mac_hi, mac_lo;
`ifdef OR1200_MAC_SATURATE_EN
  logic        sat_flag;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic        ov;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        ov;
  } mul_vec_t;

  res_t sb[$];
  res_t mon_exp;

  or1200_mac_acc #(.ACC_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .opa       (opa),
    .opb       (opb),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ov    (res_ov),
    .mac_hi    (mac_hi),
    .mac_lo    (mac_lo)
`ifdef OR1200_MAC_SATURATE_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a result is consumed on the edge following a valid&ready sample.
  always @(negedge clk) begin
    #1;
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", res_valid, 1'b0);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_res_data", res_data, mon_exp.data);
        check("sb_res_ov", res_ov, mon_exp.ov);
      end
    end
  end

  // Present one operation and hold it until accepted; result-producing ops push their expectation.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ed, input logic eov, output int stalls);
    res_t r;
    stalls = 0;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = op;
    opa      = a;
    opb      = b;
    #1;
    while (!op_ready && stalls < 20) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    if (!op_ready) begin
      check("issue_ready_timeout", op_ready, 1'b1);
    end else if (op == OP_MUL || op == OP_MACRC) begin
      r.data = ed;
      r.ov   = eov;
      sb.push_back(r);
    end
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    op_valid = 1'b0;
    #1;
  endtask

  task automatic drain();
    repeat (4) idle_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st;
    mul_vec_t vecs[8];

    vecs[0] = '{32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[5] = '{32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0};
    vecs[6] = '{32'd46341,     32'd46341,     32'h8000_1219, 1'b1};
    vecs[7] = '{32'd12345,     32'hFFFF_FC18, 32'hFF43_A158, 1'b0};

    rst_n = 1'b0; op_valid = 1'b0; op_code = 2'd0; opa = '0; opb = '0;
    flush = 1'b0; res_ready = 1'b0;

    // Reset state.
    #12;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_ov", res_ov, 1'b0);
    check("rst_op_ready", op_ready, 1'b1);
    check("rst_mac_hi", mac_hi, 32'd0);
    check("rst_mac_lo", mac_lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MUL 7 x -3: result visible two cycles after accept.
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, st);
    idle_cycle();
    check("mul_lat_cycle1_valid", res_valid, 1'b0);
    idle_cycle();
    check("mul_lat_cycle2_valid", res_valid, 1'b1);
    check("mul_lat_data", res_data, 32'hFFFF_FFEB);
    check("mul_lat_ov", res_ov, 1'b0);
    @(negedge clk);
    res_ready = 1'b1;

    // Table of MUL vectors, issued back to back.
    for (int i = 0; i < 8; i++) begin
      issue(OP_MUL, vecs[i].a, vecs[i].b, vecs[i].data, vecs[i].ov, st);
    end
    drain();

    // Back-to-back accumulate: 12 + 30 - 4 = 38, then read-and-clear.
    issue(OP_MAC, 32'd3, 32'd4, 32'd0, 1'b0, st);
    check("b2b_stall_mac1", st, 0);
    issue(OP_MAC, 32'd5, 32'd6, 32'd0, 1'b0, st);
    check("b2b_stall_mac2", st, 0);
    issue(OP_MSB, 32'd2, 32'd2, 32'd0, 1'b0, st);
    check("b2b_stall_msb", st, 0);
    issue(OP_MACRC, 32'd0, 32'd0, 32'd38, 1'b0, st);
    check("b2b_stall_macrc", st, 0);
    drain();
    check("b2b_mac_hi_clear", mac_hi, 32'd0);
    check("b2b_mac_lo_clear", mac_lo, 32'd0);

    // Signed accumulation across the 32-bit boundary.
    issue(OP_MAC, 32'hFFFF_FFFE, 32'd3, 32'd0, 1'b0, st);
    drain();
    check("neg_mac_hi", mac_hi, 32'hFFFF_FFFF);
    check("neg_mac_lo", mac_lo, 32'hFFFF_FFFA);
    issue(OP_MSB, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, st);
    drain();
    check("msb_mac_hi", mac_hi, 32'hFFFF_FFFE);
    check("msb_mac_lo", mac_lo, 32'hFFFF_FFFA);
    issue(OP_MACRC, 32'd0, 32'd0, 32'hFFFF_FFFA, 1'b0, st);
    drain();

    // Back-pressure: second MUL waits behind an untaken result.
    res_ready = 1'b0;
    issue(OP_MUL, 32'd2, 32'd3, 32'd6, 1'b0, st);
    issue(OP_MUL, 32'd4, 32'd5, 32'd20, 1'b0, st);
    idle_cycle();
    check("bp_op_ready_low", op_ready, 1'b0);
    check("bp_data_held1", res_data, 32'd6);
    idle_cycle();
    check("bp_valid_held", res_valid, 1'b1);
    check("bp_data_held2", res_data, 32'd6);
    @(negedge clk);
    res_ready = 1'b1;
    idle_cycle();
    check("bp_second_result", res_data, 32'd20);
    drain();

    // Flush one cycle after a MAC accept; the op presented with flush is dropped.
    issue(OP_MAC, 32'd1, 32'd1, 32'd0, 1'b0, st);
    @(negedge clk);
    flush = 1'b1; op_valid = 1'b1; op_code = OP_MAC; opa = 32'd5; opb = 32'd5;
    @(negedge clk);
    flush = 1'b0; op_valid = 1'b0;
    #1;
    check("flush_acc_hi", mac_hi, 32'd0);
    check("flush_acc_lo", mac_lo, 32'd0);
    idle_cycle();
    check("flush_dropped_lo", mac_lo, 32'd0);

    // Flush keeps a result already waiting in the result register.
    res_ready = 1'b0;
    issue(OP_MUL, 32'd3, 32'd3, 32'd9, 1'b0, st);
    idle_cycle();
    idle_cycle();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_keep_valid", res_valid, 1'b1);
    check("flush_keep_data", res_data, 32'd9);
    @(negedge clk);
    res_ready = 1'b1;
    drain();

    // Reset pulse with a MAC in flight.
    issue(OP_MAC, 32'd10, 32'd10, 32'd0, 1'b0, st);
    drain();
    check("pre_rst_acc_lo", mac_lo, 32'd100);
    issue(OP_MAC, 32'd2, 32'd2, 32'd0, 1'b0, st);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_res_data", res_data, 32'd0);
    check("midrst_op_ready", op_ready, 1'b1);
    check("midrst_mac_hi", mac_hi, 32'd0);
    check("midrst_mac_lo", mac_lo, 32'd0);
    op_valid = 1'b1; op_code = OP_MAC; opa = 32'd1; opb = 32'd1;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    check("postrst_not_yet", mac_lo, 32'd0);
    idle_cycle();
    check("postrst_first_edge_accept", mac_lo, 32'd1);
    issue(OP_MACRC, 32'd0, 32'd0, 32'd1, 1'b0, st);
    drain();

    // Drive the accumulator to 2^63-16, then add 16.
    issue(OP_MAC, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, st);
    issue(OP_MAC, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 1'b0, st);
    issue(OP_MAC, 32'h0001_0000, 32'h0000_FFFF, 32'd0, 1'b0, st);
    issue(OP_MAC, 32'd65519,     32'd1,         32'd0, 1'b0, st);
    drain();
    check("edge_acc_hi", mac_hi, 32'h7FFF_FFFF);
    check("edge_acc_lo", mac_lo, 32'hFFFF_FFF0);
`ifdef OR1200_MAC_SATURATE_EN
    check("sat_flag_clear_before", sat_flag, 1'b0);
`endif
    issue(OP_MAC, 32'd4, 32'd4, 32'd0, 1'b0, st);
    drain();
`ifdef OR1200_MAC_SATURATE_EN
    check("sat_acc_hi", mac_hi, 32'h7FFF_FFFF);
    check("sat_acc_lo", mac_lo, 32'hFFFF_FFFF);
    check("sat_flag_set", sat_flag, 1'b1);
    issue(OP_MACRC, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, st);
    drain();
    check("sat_flag_cleared", sat_flag, 1'b0);
`else
    check("wrap_acc_hi", mac_hi, 32'h8000_0000);
    check("wrap_acc_lo", mac_lo, 32'h0000_0000);
    issue(OP_MACRC, 32'd0, 32'd0, 32'h0000_0000, 1'b0, st);
    drain();
`endif
    check("final_mac_hi", mac_hi, 32'd0);
    check("final_mac_lo", mac_lo, 32'd0);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
